// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forward control and data-memory wait-state sequencing for the 5-stage MIPS pipeline
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteReg_EX,
  input  logic [4:0] WriteReg_MEM,
  input  logic [4:0] WriteReg_WB,
  input  logic       RegWrite_EX,
  input  logic       RegWrite_MEM,
  input  logic       RegWrite_WB,
  input  logic       MemToReg_EX,
  input  logic       MemToReg_MEM,
  input  logic       MemWrite_MEM,
  input  logic       Branch_D,
  input  logic       PCSrc_D,
  input  logic       mem_ready,
  output logic       Stall_IF,
  output logic       Stall_ID,
  output logic       Flush_ID,
  output logic       Flush_EX,
  output logic       Hold_EX,
  output logic       Hold_MEM,
  output logic       Flush_WB,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       mem_req,
  output logic       mem_err,
  output logic       mem_busy
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic lwstall, brstall, memop, timeout_hit, memstall, hz;
  // register 0 is hardwired, so a write to it never creates a dependency
  function automatic logic hit(input logic [4:0] w, input logic [4:0] r);
    return (w != 5'd0) && (w == r);
  endfunction
  always_comb begin
    ForwardAE = (RegWrite_MEM && hit(WriteReg_MEM, RsE)) ? 2'b10 :
                (RegWrite_WB && hit(WriteReg_WB, RsE)) ? 2'b01 : 2'b00;
    ForwardBE = (RegWrite_MEM && hit(WriteReg_MEM, RtE)) ? 2'b10 :
                (RegWrite_WB && hit(WriteReg_WB, RtE)) ? 2'b01 : 2'b00;
    ForwardAD = RegWrite_MEM && hit(WriteReg_MEM, RsD);
    ForwardBD = RegWrite_MEM && hit(WriteReg_MEM, RtD);
    lwstall = MemToReg_EX && (hit(WriteReg_EX, RsD) || hit(WriteReg_EX, RtD));
    brstall = Branch_D && ((RegWrite_EX && (hit(WriteReg_EX, RsD) || hit(WriteReg_EX, RtD))) ||
                           (MemToReg_MEM && (hit(WriteReg_MEM, RsD) || hit(WriteReg_MEM, RtD))));
    memop = MemToReg_MEM || MemWrite_MEM;
    timeout_hit = (state == WAIT) && (cnt == CNT_W'(MEM_TIMEOUT));
    memstall = memop && !mem_ready && !timeout_hit;
    hz = lwstall || brstall;
    // a memory stall freezes everything upstream, so it overrides the other hazards
    Stall_IF = memstall || hz;
    Stall_ID = memstall || hz;
    Flush_EX = !memstall && hz;
    Flush_ID = !memstall && PCSrc_D && !hz;
    Hold_EX = memstall;
    Hold_MEM = memstall;
    Flush_WB = memstall;
    mem_req = (state == WAIT) || memop;
    mem_busy = (state == WAIT);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      mem_err <= 1'b0;
    end else if (state == IDLE) begin
      if (memop && !mem_ready) begin
        state <= WAIT;
        cnt <= CNT_W'(1);
      end
    end else if (mem_ready || timeout_hit) begin
      state <= IDLE;
      cnt <= '0;
      if (!mem_ready) mem_err <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of forwarding, hazard stalls and memory wait/timeout sequencing
module tb_pipe_hazard_ctrl;
  logic clk = 0, reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteReg_EX, WriteReg_MEM, WriteReg_WB;
  logic RegWrite_EX, RegWrite_MEM, RegWrite_WB, MemToReg_EX, MemToReg_MEM, MemWrite_MEM;
  logic Branch_D, PCSrc_D, mem_ready;
  logic Stall_IF, Stall_ID, Flush_ID, Flush_EX, Hold_EX, Hold_MEM, Flush_WB;
  logic [1:0] ForwardAE, ForwardBE;
  logic ForwardAD, ForwardBD, mem_req, mem_err, mem_busy;
  logic [6:0] ctl;
  int n_tests = 0, n_fail = 0;
  localparam logic [6:0] MEMSTALL = 7'b1100111, HZSTALL = 7'b1101000, FLUSH = 7'b0010000;
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteReg_EX(WriteReg_EX), .WriteReg_MEM(WriteReg_MEM), .WriteReg_WB(WriteReg_WB),
    .RegWrite_EX(RegWrite_EX), .RegWrite_MEM(RegWrite_MEM), .RegWrite_WB(RegWrite_WB),
    .MemToReg_EX(MemToReg_EX), .MemToReg_MEM(MemToReg_MEM), .MemWrite_MEM(MemWrite_MEM),
    .Branch_D(Branch_D), .PCSrc_D(PCSrc_D), .mem_ready(mem_ready),
    .Stall_IF(Stall_IF), .Stall_ID(Stall_ID), .Flush_ID(Flush_ID), .Flush_EX(Flush_EX),
    .Hold_EX(Hold_EX), .Hold_MEM(Hold_MEM), .Flush_WB(Flush_WB),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .mem_req(mem_req), .mem_err(mem_err), .mem_busy(mem_busy)
  );
  assign ctl = {Stall_IF, Stall_ID, Flush_ID, Flush_EX, Hold_EX, Hold_MEM, Flush_WB};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    {RsD, RtD, RsE, RtE, WriteReg_EX, WriteReg_MEM, WriteReg_WB} = '0;
    {RegWrite_EX, RegWrite_MEM, RegWrite_WB, MemToReg_EX, MemToReg_MEM, MemWrite_MEM} = '0;
    {Branch_D, PCSrc_D, mem_ready} = '0;
  endtask
  initial begin
    clr();
    reset = 1;
    tick();
    tick();
    reset = 0;
    #1;
    chk("rst_ctl", ctl, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_busy", mem_busy, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_fwd", {ForwardAE, ForwardBE, ForwardAD, ForwardBD}, 0);
    // EX forwarding priority
    RegWrite_MEM = 1; WriteReg_MEM = 8; RegWrite_WB = 1; WriteReg_WB = 8; RsE = 8; RtE = 8;
    #1;
    chk("fae_mem", ForwardAE, 2'b10);
    chk("fbe_mem", ForwardBE, 2'b10);
    RegWrite_MEM = 0;
    #1;
    chk("fae_wb", ForwardAE, 2'b01);
    WriteReg_WB = 0; RsE = 0;
    #1;
    chk("fae_r0", ForwardAE, 2'b00);
    RegWrite_MEM = 1; WriteReg_MEM = 0; RtE = 0;
    #1;
    chk("fbe_r0", ForwardBE, 2'b00);
    clr();
    // load-use with a taken branch: stall wins
    MemToReg_EX = 1; WriteReg_EX = 9; RtD = 9; PCSrc_D = 1;
    #1;
    chk("lw_ctl", ctl, HZSTALL);
    MemToReg_EX = 0;
    #1;
    chk("pcsrc_flush", ctl, FLUSH);
    clr();
    // branch hazard, then forwarded from MEM
    Branch_D = 1; RegWrite_EX = 1; WriteReg_EX = 4; RsD = 4;
    #1;
    chk("br_stall", ctl, HZSTALL);
    tick();
    RegWrite_EX = 0; WriteReg_EX = 0; RegWrite_MEM = 1; WriteReg_MEM = 4;
    #1;
    chk("br_fad", {ForwardAD, ForwardBD}, 2'b10);
    chk("br_nostall", ctl, 0);
    PCSrc_D = 1;
    #1;
    chk("br_flush", ctl, FLUSH);
    MemToReg_MEM = 1; mem_ready = 1;
    #1;
    chk("br_ld_mem", ctl, HZSTALL);
    tick();
    clr();
    // three wait states then ready
    MemToReg_MEM = 1;
    #1;
    chk("mw1_ctl", ctl, MEMSTALL);
    chk("mw1_req", mem_req, 1);
    chk("mw1_busy", mem_busy, 0);
    for (int i = 2; i <= 3; i++) begin
      tick();
      chk($sformatf("mw%0d_ctl", i), ctl, MEMSTALL);
      chk($sformatf("mw%0d_busy", i), mem_busy, 1);
      chk($sformatf("mw%0d_req", i), mem_req, 1);
    end
    tick();
    mem_ready = 1;
    #1;
    chk("mw4_ctl", ctl, 0);
    chk("mw4_req", mem_req, 1);
    chk("mw4_busy", mem_busy, 1);
    tick();
    clr();
    #1;
    chk("mw5_busy", mem_busy, 0);
    chk("mw5_req", mem_req, 0);
    // zero-wait access
    MemToReg_MEM = 1; mem_ready = 1;
    #1;
    chk("zw_ctl", ctl, 0);
    chk("zw_req", mem_req, 1);
    tick();
    chk("zw_busy", mem_busy, 0);
    clr();
    // timeout at 4
    MemWrite_MEM = 1;
    #1;
    chk("to1_ctl", ctl, MEMSTALL);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("to_cnt%0d_ctl", i), ctl, MEMSTALL);
    end
    tick();
    chk("to_hit_ctl", ctl, 0);
    chk("to_hit_busy", mem_busy, 1);
    chk("to_hit_err", mem_err, 0);
    tick();
    MemWrite_MEM = 0;
    #1;
    chk("to_idle_busy", mem_busy, 0);
    chk("to_err", mem_err, 1);
    tick();
    chk("to_err_sticky", mem_err, 1);
    // reset in the second WAIT cycle
    MemToReg_MEM = 1;
    tick();
    tick();
    chk("rw_busy", mem_busy, 1);
    chk("rw_err_pre", mem_err, 1);
    reset = 1;
    tick();
    reset = 0;
    MemToReg_MEM = 0;
    #1;
    chk("rw_busy_post", mem_busy, 0);
    chk("rw_err_post", mem_err, 0);
    chk("rw_ctl_post", ctl, 0);
    chk("rw_req_post", mem_req, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
